// File: rtl/hex_reg_bank.sv
// hex_reg_bank: NUM_CH Avalon-MM data registers plus a CTRL register; one register is exported to the hex display.
// Timed auto-scan of the channels (dwell counter, CTRL.SCAN) is built only when HEX_AUTOSCAN_EN is defined.
module hex_reg_bank #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 3,
    parameter int DWELL  = 50000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic [DATA_W-1:0] to_hex_export,
    output logic [3:0]        to_hex_channel,
    output logic              to_hex_update
);
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_CH);
    localparam logic [4:0]        NUM_CH_5  = 5'(NUM_CH);

    logic [DATA_W-1:0] data_regs [NUM_CH];
    logic              freeze_q;
    logic [3:0]        sel_q;
    logic              scan_bit;
    logic              ctrl_wr_lane0;
    logic [31:0]       be_mask;
    logic [31:0]       ctrl_view;
    logic [31:0]       rd_view;
    logic [3:0]        manual_ch;
    logic [3:0]        eff_ch;
    logic [DATA_W-1:0] eff_data;

    function automatic logic [3:0] clamp_ch(input logic [3:0] s);
        return ({1'b0, s} >= NUM_CH_5) ? 4'd0 : s;
    endfunction

    // All writable CTRL fields live in byte lane 0.
    assign ctrl_wr_lane0 = avs_write && (avs_address == CTRL_ADDR) && avs_byteenable[0];
    assign be_mask   = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                        {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
    assign ctrl_view = {12'd0, to_hex_channel, 8'd0, sel_q, 2'd0, freeze_q, scan_bit};
    assign manual_ch = clamp_ch(sel_q);

    always_comb begin
        rd_view = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (avs_address == ADDR_W'(i)) rd_view = 32'(data_regs[i]);
        end
        if (avs_address == CTRL_ADDR) rd_view = ctrl_view;
    end

    always_comb begin
        eff_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (eff_ch == 4'(i)) eff_data = data_regs[i];
        end
    end

    // Byte lanes above DATA_W fall off in the truncating cast.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < NUM_CH; i++) data_regs[i] <= '0;
            freeze_q <= 1'b0;
            sel_q    <= 4'd0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (avs_write && (avs_address == ADDR_W'(i)))
                    data_regs[i] <= DATA_W'((32'(data_regs[i]) & ~be_mask) | (avs_writedata & be_mask));
            end
            if (ctrl_wr_lane0) begin
                freeze_q <= avs_writedata[1];
                sel_q    <= avs_writedata[7:4];
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            avs_readdata      <= 32'd0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) avs_readdata <= rd_view;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            to_hex_export  <= '0;
            to_hex_channel <= 4'd0;
            to_hex_update  <= 1'b0;
        end else if (!freeze_q) begin
            to_hex_export  <= eff_data;
            to_hex_channel <= eff_ch;
            to_hex_update  <= (eff_data != to_hex_export);
        end else begin
            to_hex_update  <= 1'b0;
        end
    end

`ifdef HEX_AUTOSCAN_EN
    localparam int              CNT_W      = $clog2(DWELL);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [3:0]      LAST_CH    = 4'(NUM_CH - 1);

    logic             scan_q;
    logic [CNT_W-1:0] dwell_cnt;
    logic [3:0]       scan_ch;

    // A SCAN 0->1 write restarts the dwell at the clamped SEL carried by that same write.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            scan_q    <= 1'b0;
            dwell_cnt <= '0;
            scan_ch   <= 4'd0;
        end else begin
            if (ctrl_wr_lane0) scan_q <= avs_writedata[0];
            if (ctrl_wr_lane0 && avs_writedata[0] && !scan_q) begin
                dwell_cnt <= '0;
                scan_ch   <= clamp_ch(avs_writedata[7:4]);
            end else if (scan_q && !freeze_q) begin
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_cnt <= '0;
                    scan_ch   <= (scan_ch == LAST_CH) ? 4'd0 : scan_ch + 4'd1;
                end else begin
                    dwell_cnt <= dwell_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign scan_bit = scan_q;
    assign eff_ch   = scan_q ? scan_ch : manual_ch;
`else
    assign scan_bit = 1'b0;
    assign eff_ch   = manual_ch;
`endif

endmodule

// File: tb/tb_hex_reg_bank.sv
// Self-checking bench for hex_reg_bank: directed vector table, hand sequences and randomized traffic
// compared against a behavioural model (scan position derived from elapsed dwell ticks).
module tb_hex_reg_bank;
    localparam int DATA_W = 16;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 3;
    localparam int DWELL  = 4;

    logic              clk_clk;
    logic              reset_reset;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic              avs_read;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;
    logic [DATA_W-1:0] to_hex_export;
    logic [3:0]        to_hex_channel;
    logic              to_hex_update;

    hex_reg_bank #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DWELL(DWELL)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .avs_address(avs_address),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_byteenable(avs_byteenable),
        .avs_read(avs_read),
        .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .to_hex_export(to_hex_export),
        .to_hex_channel(to_hex_channel),
        .to_hex_update(to_hex_update)
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [DATA_W-1:0] m_data [NUM_CH];
    logic              m_scan, m_freeze, m_valid, m_upd;
    int                m_sel, m_start, m_ticks, m_chan;
    logic [31:0]       m_rdata;
    logic [DATA_W-1:0] m_exp;

    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rd;
        logic        exp_valid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [17];

    logic [2:0]  r_addr;
    logic        r_wr, r_rd;
    logic [31:0] r_wd;
    logic [3:0]  r_be;
    int          kind;
    int          n_wait;
    int          scan_seq [5];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int m_clamp(input int s);
        return (s >= NUM_CH) ? 0 : s;
    endfunction

    function automatic int m_channel();
        return m_scan ? (m_start + m_ticks / DWELL) % NUM_CH : m_clamp(m_sel);
    endfunction

    function automatic logic [31:0] m_view(input int a);
        if (a < NUM_CH) return 32'(m_data[a]);
        if (a == NUM_CH) return {12'd0, 4'(m_chan), 8'd0, 4'(m_sel), 2'd0, m_freeze, m_scan};
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) m_data[i] = '0;
        m_scan = 1'b0; m_freeze = 1'b0; m_valid = 1'b0; m_upd = 1'b0;
        m_sel = 0; m_start = 0; m_ticks = 0; m_chan = 0;
        m_rdata = 32'd0; m_exp = '0;
    endtask

    // Advances the model by one clock edge given the bus inputs held before that edge.
    task automatic model_step(input int a, input logic w, input logic [31:0] wd,
                              input logic [3:0] be, input logic r);
        int ch;
        logic [31:0] view, nv;
        ch   = m_channel();
        view = m_view(a);
        if (r) m_rdata = view;
        m_valid = r;
        if (!m_freeze) begin
            m_upd  = (m_data[ch] != m_exp);
            m_exp  = m_data[ch];
            m_chan = ch;
            if (m_scan) m_ticks++;
        end else begin
            m_upd = 1'b0;
        end
        if (w) begin
            nv = view;
            for (int k = 0; k < 4; k++) if (be[k]) nv[8*k +: 8] = wd[8*k +: 8];
            if (a < NUM_CH) begin
                m_data[a] = nv[DATA_W-1:0];
            end else if (a == NUM_CH) begin
`ifdef HEX_AUTOSCAN_EN
                if (nv[0] && !m_scan) begin
                    m_start = m_clamp(int'(nv[7:4]));
                    m_ticks = 0;
                end
                m_scan = nv[0];
`endif
                m_freeze = nv[1];
                m_sel    = int'(nv[7:4]);
            end
        end
    endtask

    task automatic check_model();
        check_output("valid",   32'(avs_readdatavalid), 32'(m_valid));
        check_output("rdata",   avs_readdata, m_rdata);
        check_output("export",  32'(to_hex_export), 32'(m_exp));
        check_output("channel", 32'(to_hex_channel), 32'(m_chan));
        check_output("update",  32'(to_hex_update), 32'(m_upd));
    endtask

    task automatic apply_stimulus(input logic [2:0] a, input logic w, input logic [31:0] wd,
                                  input logic [3:0] be, input logic r);
        avs_address    = a;
        avs_write      = w;
        avs_writedata  = wd;
        avs_byteenable = be;
        avs_read       = r;
        model_step(int'(a), w, wd, be, r);
        @(posedge clk_clk);
        #1;
        avs_write = 1'b0;
        avs_read  = 1'b0;
        check_model();
    endtask

    task automatic idle();
        apply_stimulus(3'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    endtask

    initial begin
        reset_reset    = 1'b1;
        avs_address    = '0;
        avs_write      = 1'b0;
        avs_writedata  = 32'd0;
        avs_byteenable = 4'd0;
        avs_read       = 1'b0;
        model_reset();

        vecs[0]  = '{3'd0, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[1]  = '{3'd1, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[2]  = '{3'd2, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[3]  = '{3'd3, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[4]  = '{3'd4, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[5]  = '{3'd5, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[6]  = '{3'd0, 1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[7]  = '{3'd2, 1'b1, 32'h0000_ABCD, 4'h1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[8]  = '{3'd2, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_00CD};
        vecs[9]  = '{3'd2, 1'b1, 32'h0000_ABCD, 4'h2, 1'b0, 1'b0, 32'h0000_0000};
        vecs[10] = '{3'd2, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_ABCD};
        vecs[11] = '{3'd2, 1'b1, 32'h5555_0000, 4'hC, 1'b0, 1'b0, 32'h0000_0000};
        vecs[12] = '{3'd2, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_ABCD};
        vecs[13] = '{3'd6, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 32'h0000_0000};
        vecs[14] = '{3'd6, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[15] = '{3'd1, 1'b1, 32'h0000_1234, 4'h3, 1'b1, 1'b1, 32'h0000_0000};
        vecs[16] = '{3'd1, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1, 32'h0000_1234};

        repeat (2) @(posedge clk_clk);
        #1;
        check_model();
        reset_reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].addr, vecs[i].wr, vecs[i].wd, vecs[i].be, vecs[i].rd);
            check_output($sformatf("tbl%0d_valid", i), 32'(avs_readdatavalid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check_output($sformatf("tbl%0d_rdata", i), avs_readdata, vecs[i].exp_rdata);
        end

        // Manual selection of reg2, then an equal-value rewrite must not pulse update
        apply_stimulus(3'd2, 1'b1, 32'h0000_1234, 4'h3, 1'b0);
        apply_stimulus(3'd4, 1'b1, 32'h0000_0020, 4'h1, 1'b0);
        idle();
        check_output("sel2_export", 32'(to_hex_export), 32'h1234);
        check_output("sel2_channel", 32'(to_hex_channel), 32'd2);
        check_output("sel2_update", 32'(to_hex_update), 32'd1);
        idle();
        check_output("sel2_pulse_end", 32'(to_hex_update), 32'd0);
        apply_stimulus(3'd2, 1'b1, 32'h0000_1234, 4'h3, 1'b0);
        idle();
        check_output("same_val_upd_a", 32'(to_hex_update), 32'd0);
        idle();
        check_output("same_val_upd_b", 32'(to_hex_update), 32'd0);

        // Out-of-range SEL clamps to channel 0
        apply_stimulus(3'd4, 1'b1, 32'h0000_0070, 4'h1, 1'b0);
        idle();
        check_output("sel7_channel", 32'(to_hex_channel), 32'd0);
        check_output("sel7_export", 32'(to_hex_export), 32'd0);

        apply_stimulus(3'd0, 1'b1, 32'h0000_1111, 4'h3, 1'b0);
        apply_stimulus(3'd1, 1'b1, 32'h0000_2222, 4'h3, 1'b0);
        apply_stimulus(3'd2, 1'b1, 32'h0000_3333, 4'h3, 1'b0);
        apply_stimulus(3'd3, 1'b1, 32'h0000_4444, 4'h3, 1'b0);

`ifdef HEX_AUTOSCAN_EN
        scan_seq = '{3, 0, 1, 2, 3};
        apply_stimulus(3'd4, 1'b1, 32'h0000_0031, 4'h1, 1'b0);
        for (int n = 1; n <= 17; n++) begin
            idle();
            check_output($sformatf("scan_ch_%0d", n), 32'(to_hex_channel), 32'(scan_seq[(n - 1) / 4]));
        end
        apply_stimulus(3'd4, 1'b1, 32'h0000_0033, 4'h1, 1'b0);
        for (int n = 0; n < 6; n++) begin
            idle();
            check_output("freeze_hold_ch", 32'(to_hex_channel), 32'd3);
            check_output("freeze_no_upd", 32'(to_hex_update), 32'd0);
        end
        apply_stimulus(3'd4, 1'b1, 32'h0000_0031, 4'h1, 1'b0);
        n_wait = 0;
        while (n_wait < 12) begin
            idle();
            n_wait++;
            if (to_hex_channel == 4'd0) break;
        end
        check_output("release_dwell", 32'(n_wait), 32'd3);
        apply_stimulus(3'd4, 1'b0, 32'd0, 4'h0, 1'b1);
`else
        apply_stimulus(3'd4, 1'b1, 32'h0000_0031, 4'h1, 1'b0);
        apply_stimulus(3'd4, 1'b0, 32'd0, 4'h0, 1'b1);
        check_output("noscan_ctrl_a", avs_readdata, 32'h0000_0030);
        apply_stimulus(3'd4, 1'b0, 32'd0, 4'h0, 1'b1);
        check_output("noscan_ctrl_b", avs_readdata, 32'h0003_0030);
`endif

        // Reset lands while a read is pending: no valid follows and outputs clear at once
        avs_address = 3'd1;
        avs_read    = 1'b1;
        #3;
        reset_reset = 1'b1;
        #1;
        model_reset();
        check_output("rst_async_export", 32'(to_hex_export), 32'd0);
        check_output("rst_async_rdata", avs_readdata, 32'd0);
        check_output("rst_async_valid", 32'(avs_readdatavalid), 32'd0);
        check_output("rst_async_chan", 32'(to_hex_channel), 32'd0);
        @(posedge clk_clk);
        #1;
        avs_read = 1'b0;
        check_output("rst_read_dropped", 32'(avs_readdatavalid), 32'd0);
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        for (int a = 0; a < NUM_CH + 2; a++) begin
            apply_stimulus(3'(a), 1'b0, 32'd0, 4'h0, 1'b1);
            check_output($sformatf("post_rst_rd%0d", a), avs_readdata, 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            kind   = $urandom_range(0, 9);
            r_addr = 3'($urandom_range(0, 7));
            r_wr   = 1'b0;
            r_rd   = 1'($urandom_range(0, 1));
            r_be   = 4'($urandom);
            r_wd   = $urandom;
            if (kind < 4) begin
                r_wr   = 1'b1;
                r_addr = 3'($urandom_range(0, NUM_CH - 1));
                case ($urandom_range(0, 2))
                    0:       r_wd = 32'h0000_1234;
                    1:       r_wd = 32'(m_exp);
                    default: r_wd = $urandom;
                endcase
            end else if (kind == 4) begin
                r_wr   = 1'b1;
                r_addr = 3'(NUM_CH);
                r_wd   = {24'd0, 4'($urandom_range(0, 7)), 2'b00,
                          ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
            end else if (kind == 5) begin
                r_wr = 1'b1;
            end
            apply_stimulus(r_addr, r_wr, r_wd, r_be, r_rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
